// File: rtl/riscv_pkg.sv
// Shared core definitions: register-index width, the x0 index and the hazard FSM state type.
package riscv_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HOLD   = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_perf.sv
// Three saturating event counters for stall, flush and memory-hold statistics.
module hazard_perf #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    input  logic             hold_inc_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] hold_cnt_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] hold_q,  hold_d;

    // Increment only below all-ones so the counters stick at their maximum.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        hold_d  = hold_q;
        if (stall_inc_i && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
        if (flush_inc_i && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
        if (hold_inc_i  && (hold_q  != '1)) hold_d  = hold_q  + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
            hold_q  <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            hold_q  <= hold_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
    assign hold_cnt_o  = hold_q;

endmodule

// File: rtl/hazard_unit.sv
// RV32I pipeline hazard controller: load-use stall, EX redirect flush, data-memory hold.
// Define HAZARD_PERF_EN to build the stall/flush/hold statistics counters.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             Controlen,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] hold_cnt
);

    hz_state_t state_q, state_d;
    logic      luh;

    assign luh = ex_mem_read && (ex_rd != REG_X0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // HOLD shares the RUN/BUBBLE priority chain: while dmem_busy the hold branch
    // masks redirect and load-use, and on release the same chain acts normally.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        Controlen  = 1'b0;
        pipe_hold  = 1'b0;
        case (state_q)
            INIT: begin
                ifid_flush = 1'b1;
                state_d    = RUN;
            end
            default: begin
                if (dmem_busy) begin
                    pipe_hold = 1'b1;
                    Controlen = 1'b1;
                    state_d   = HOLD;
                end else if (ex_redirect) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                    state_d    = RUN;
                end else if (luh) begin
                    state_d = BUBBLE;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    Controlen  = 1'b1;
                    state_d    = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= INIT;
        else       state_q <= state_d;
    end

`ifdef HAZARD_PERF_EN
    logic stall_inc, flush_inc, hold_inc;

    // Outside INIT, a bubble without flush is a load-use stall; a flush with PC load is a redirect.
    assign stall_inc = !Controlen && !ifid_flush && !pipe_hold;
    assign flush_inc = ifid_flush && pc_write;
    assign hold_inc  = pipe_hold;

    hazard_perf #(.CNT_W(CNT_W)) u_perf (
        .clk         (clk),
        .reset       (reset),
        .stall_inc_i (stall_inc),
        .flush_inc_i (flush_inc),
        .hold_inc_i  (hold_inc),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
        .hold_cnt_o  (hold_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign hold_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic vs a behavioural model.
module tb_hazard_unit;

    localparam int unsigned CNT_W = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       ex_mem_read = 1'b0, ex_redirect = 1'b0, dmem_busy = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, Controlen, pipe_hold;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, hold_cnt;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_redirect (ex_redirect),
        .dmem_busy   (dmem_busy),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .Controlen   (Controlen),
        .pipe_hold   (pipe_hold),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .hold_cnt    (hold_cnt)
    );

    always #5 clk = ~clk;

    // {pc_write, ifid_write, ifid_flush, Controlen, pipe_hold}
    wire [4:0]         outs = {pc_write, ifid_write, ifid_flush, Controlen, pipe_hold};
    wire [3*CNT_W-1:0] cnts = {stall_cnt, flush_cnt, hold_cnt};

    int checks = 0;
    int errors = 0;

    // Reference model: only "first cycle after reset" matters for outputs; counters are plain tallies.
    bit               m_init  = 1'b1;
    logic [CNT_W-1:0] m_stall = '0, m_flush = '0, m_hold = '0;

    // 0 = memory wait, 1 = redirect, 2 = load-use stall, 3 = normal flow
    function automatic int event_kind();
        bit hit1, hit2;
        hit1 = id_use_rs1 && (int'(id_rs1) == int'(ex_rd));
        hit2 = id_use_rs2 && (int'(id_rs2) == int'(ex_rd));
        if (dmem_busy)                                     return 0;
        if (ex_redirect)                                   return 1;
        if (ex_mem_read && int'(ex_rd) != 0 && (hit1 || hit2)) return 2;
        return 3;
    endfunction

    function automatic logic [4:0] exp_outs();
        if (reset || m_init) return 5'b00100;
        case (event_kind())
            0:       return 5'b00011;
            1:       return 5'b11100;
            2:       return 5'b00000;
            default: return 5'b11010;
        endcase
    endfunction

    function automatic logic [3*CNT_W-1:0] exp_cnts();
`ifdef HAZARD_PERF_EN
        return {m_stall, m_flush, m_hold};
`else
        return '0;
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_init  <= 1'b1;
            m_stall <= '0;
            m_flush <= '0;
            m_hold  <= '0;
        end else if (m_init) begin
            m_init <= 1'b0;
        end else begin
            case (event_kind())
                0: m_hold  <= m_hold + 1;
                1: m_flush <= m_flush + 1;
                2: m_stall <= m_stall + 1;
                default: ;
            endcase
        end
    end

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic mr,
                          input logic redir, input logic busy);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_redirect = redir; dmem_busy = busy;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00100) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, 5'b00100); end
        checks++;
        if (cnts !== '0) begin errors++; $display("FAIL reset_cnts got=%h exp=0", cnts); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00100) begin errors++; $display("FAIL init_cycle got=%b exp=%b", outs, 5'b00100); end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 5'b11010) begin errors++; $display("FAIL first_run got=%b exp=%b", outs, 5'b11010); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        logic [4:0] exp_seq [4] = '{5'b00000, 5'b11010, 5'b00000, 5'b00000};
        for (int i = 0; i < 4; i++) begin
            if (i == 1) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            else        set_in(5'd7, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
            #1;
            checks++;
            if (outs !== exp_seq[i]) begin errors++; $display("FAIL load_use[%0d] got=%b exp=%b", i, outs, exp_seq[i]); end
            @(negedge clk);
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 5'b11010) begin errors++; $display("FAIL after_bubble got=%b exp=%b", outs, 5'b11010); end
        checks++;
        if (cnts !== exp_cnts()) begin errors++; $display("FAIL load_use_cnts got=%h exp=%h", cnts, exp_cnts()); end
        @(negedge clk);
    endtask

    task automatic test_no_stall();
        set_in(5'd3, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 5'b11010) begin errors++; $display("FAIL rd_x0 got=%b exp=%b", outs, 5'b11010); end
        @(negedge clk);
        set_in(5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 5'b11010) begin errors++; $display("FAIL no_use got=%b exp=%b", outs, 5'b11010); end
        @(negedge clk);
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 5'b11010) begin errors++; $display("FAIL not_load got=%b exp=%b", outs, 5'b11010); end
        @(negedge clk);
    endtask

    task automatic test_redirect_luh();
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (outs !== 5'b11100) begin errors++; $display("FAIL redirect_luh got=%b exp=%b", outs, 5'b11100); end
        @(negedge clk);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 5'b11010) begin errors++; $display("FAIL post_redirect got=%b exp=%b", outs, 5'b11010); end
        checks++;
        if (cnts !== exp_cnts()) begin errors++; $display("FAIL redirect_cnts got=%h exp=%h", cnts, exp_cnts()); end
        @(negedge clk);
    endtask

    task automatic test_hold_redirect();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (outs !== 5'b00011) begin errors++; $display("FAIL hold[%0d] got=%b exp=%b", i, outs, 5'b00011); end
            @(negedge clk);
        end
        dmem_busy = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b11100) begin errors++; $display("FAIL hold_release got=%b exp=%b", outs, 5'b11100); end
        @(negedge clk);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 5'b11010) begin errors++; $display("FAIL after_hold got=%b exp=%b", outs, 5'b11010); end
        checks++;
        if (cnts !== exp_cnts()) begin errors++; $display("FAIL hold_cnts got=%h exp=%h", cnts, exp_cnts()); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_hold();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00100) begin errors++; $display("FAIL reset_mid_hold got=%b exp=%b", outs, 5'b00100); end
        checks++;
        if (cnts !== '0) begin errors++; $display("FAIL reset_mid_hold_cnts got=%h exp=0", cnts); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00100) begin errors++; $display("FAIL init_after_hold got=%b exp=%b", outs, 5'b00100); end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 5'b00011) begin errors++; $display("FAIL hold_after_init got=%b exp=%b", outs, 5'b00011); end
        @(negedge clk);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
            #1;
            checks++;
            if (outs !== exp_outs()) begin errors++; $display("FAIL random_outs[%0d] got=%b exp=%b", i, outs, exp_outs()); end
            checks++;
            if (cnts !== exp_cnts()) begin errors++; $display("FAIL random_cnts[%0d] got=%h exp=%h", i, cnts, exp_cnts()); end
            @(negedge clk);
        end
        reset = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect_luh();
        test_hold_redirect();
        test_reset_in_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
